// File: rtl/sme_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sme_driver: buffers one string and one pattern from a host, streams them   |
// | to the matching engine and holds the captured result.       Rev 1.0        |
// +----------------------------------------------------------------------------+
module sme_driver #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       res_match,
  output logic [5:0] res_index,
  output logic       res_timeout,
  output logic       overflow,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [5:0] match_index
);

  localparam int STR_LEN_W = $clog2(STR_MAX + 1);
  localparam int PAT_LEN_W = $clog2(PAT_MAX + 1);
  localparam int STR_AW    = $clog2(STR_MAX);
  localparam int PAT_AW    = $clog2(PAT_MAX);
  localparam int IDX_W     = (STR_LEN_W > PAT_LEN_W) ? STR_LEN_W : PAT_LEN_W;
  localparam int CNT_W     = $clog2(TIMEOUT + 1);

  localparam logic [STR_LEN_W-1:0] C_STR_FULL = STR_LEN_W'(STR_MAX);
  localparam logic [PAT_LEN_W-1:0] C_PAT_FULL = PAT_LEN_W'(PAT_MAX);
  localparam logic [CNT_W-1:0]     C_TIMEOUT  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND_STR = 3'd1,
    S_SEND_PAT = 3'd2,
    S_WAIT     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_str_mem [STR_MAX];
  logic [7:0]             r_pat_mem [PAT_MAX];
  logic [STR_LEN_W-1:0]   r_str_len, w_str_len_nxt;
  logic [PAT_LEN_W-1:0]   r_pat_len, w_pat_len_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt, w_idx_inc;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   w_str_wr, w_pat_wr;
  logic [7:0]             w_chardata_nxt;
  logic                   w_isstring_nxt, w_ispattern_nxt, w_done_nxt;
  logic                   w_res_match_nxt, w_res_timeout_nxt, w_overflow_nxt;
  logic [5:0]             w_res_index_nxt;

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    w_state_nxt       = r_state;
    w_str_len_nxt     = r_str_len;
    w_pat_len_nxt     = r_pat_len;
    w_idx_inc         = r_idx + 1'b1;
    w_idx_nxt         = r_idx;
    w_cnt_nxt         = r_cnt;
    w_str_wr          = 1'b0;
    w_pat_wr          = 1'b0;
    w_chardata_nxt    = 8'd0;
    w_isstring_nxt    = 1'b0;
    w_ispattern_nxt   = 1'b0;
    w_done_nxt        = 1'b0;
    w_res_match_nxt   = res_match;
    w_res_index_nxt   = res_index;
    w_res_timeout_nxt = res_timeout;
    w_overflow_nxt    = overflow;

    case (r_state)
      S_IDLE: begin
        if (start && (r_pat_len != '0)) begin
          w_res_match_nxt   = 1'b0;
          w_res_index_nxt   = 6'd0;
          w_res_timeout_nxt = 1'b0;
          w_overflow_nxt    = 1'b0;
          w_idx_nxt         = '0;
          if (r_str_len != '0) begin
            w_state_nxt    = S_SEND_STR;
            w_chardata_nxt = r_str_mem[0];
            w_isstring_nxt = 1'b1;
          end else begin
            // Pattern-only job: the engine keeps its previous string.
            w_state_nxt     = S_SEND_PAT;
            w_chardata_nxt  = r_pat_mem[0];
            w_ispattern_nxt = 1'b1;
          end
        end else if (wr_en) begin
          if (!wr_sel) begin
            if (r_str_len == C_STR_FULL) begin
              w_overflow_nxt = 1'b1;
            end else begin
              w_str_wr      = 1'b1;
              w_str_len_nxt = r_str_len + 1'b1;
            end
          end else begin
            if (r_pat_len == C_PAT_FULL) begin
              w_overflow_nxt = 1'b1;
            end else begin
              w_pat_wr      = 1'b1;
              w_pat_len_nxt = r_pat_len + 1'b1;
            end
          end
        end
      end

      S_SEND_STR: begin
        if (w_idx_inc == IDX_W'(r_str_len)) begin
          w_state_nxt     = S_SEND_PAT;
          w_idx_nxt       = '0;
          w_chardata_nxt  = r_pat_mem[0];
          w_ispattern_nxt = 1'b1;
        end else begin
          w_idx_nxt      = w_idx_inc;
          w_chardata_nxt = r_str_mem[w_idx_inc[STR_AW-1:0]];
          w_isstring_nxt = 1'b1;
        end
      end

      S_SEND_PAT: begin
        if (w_idx_inc == IDX_W'(r_pat_len)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_idx_nxt       = w_idx_inc;
          w_chardata_nxt  = r_pat_mem[w_idx_inc[PAT_AW-1:0]];
          w_ispattern_nxt = 1'b1;
        end
      end

      S_WAIT: begin
        // A valid arriving on the final count still wins over the timeout.
        if (valid) begin
          w_state_nxt       = S_DONE;
          w_done_nxt        = 1'b1;
          w_res_match_nxt   = match;
          w_res_index_nxt   = match_index;
          w_res_timeout_nxt = 1'b0;
        end else if (r_cnt == C_TIMEOUT) begin
          w_state_nxt       = S_DONE;
          w_done_nxt        = 1'b1;
          w_res_match_nxt   = 1'b0;
          w_res_index_nxt   = 6'd0;
          w_res_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt   = S_IDLE;
        w_str_len_nxt = '0;
        w_pat_len_nxt = '0;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_str_len   <= '0;
      r_pat_len   <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= 6'd0;
      res_timeout <= 1'b0;
      overflow    <= 1'b0;
      chardata    <= 8'd0;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_str_len   <= w_str_len_nxt;
      r_pat_len   <= w_pat_len_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      busy        <= (w_state_nxt != S_IDLE);
      done        <= w_done_nxt;
      res_match   <= w_res_match_nxt;
      res_index   <= w_res_index_nxt;
      res_timeout <= w_res_timeout_nxt;
      overflow    <= w_overflow_nxt;
      chardata    <= w_chardata_nxt;
      isstring    <= w_isstring_nxt;
      ispattern   <= w_ispattern_nxt;
    end
  end

  // Buffer storage survives reset; only the lengths are cleared.
  always_ff @(posedge clk) begin
    if (reset && w_str_wr) begin
      r_str_mem[r_str_len[STR_AW-1:0]] <= wr_data;
    end
    if (reset && w_pat_wr) begin
      r_pat_mem[r_pat_len[PAT_AW-1:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sme_driver.sv
`default_nettype none
// Bench for sme_driver: queue-based job model compared every cycle,
// plus directed scenarios pinned with hand-computed values.
module tb_sme_driver;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       match = 1'b0;
  logic [5:0] match_index = 6'd0;
  logic       busy, done, res_match, res_timeout, overflow, isstring, ispattern;
  logic [5:0] res_index;
  logic [7:0] chardata;

  sme_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .res_match(res_match),
    .res_index(res_index), .res_timeout(res_timeout), .overflow(overflow),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- behavioural model ----------------
  typedef struct packed {logic [7:0] c; logic s; logic p;} emit_t;
  emit_t       m_q[$];
  byte unsigned m_str[$];
  byte unsigned m_pat[$];
  int          m_phase = 0;  // 0 idle, 1 streaming, 2 waiting, 3 result
  int          m_wcnt = 0;
  logic        m_ovf = 0, m_rm = 0, m_rt = 0;
  logic [5:0]  m_ri = 0;
  logic [7:0]  e_cd = 0;
  logic        e_is = 0, e_ip = 0, e_busy = 0, e_done = 0;

  task automatic pop_emit();
    emit_t e;
    e = m_q.pop_front();
    e_cd = e.c;
    e_is = e.s;
    e_ip = e.p;
  endtask

  always @(posedge clk) begin
    emit_t e;
    cyc++;
    e_done = 0; e_cd = 0; e_is = 0; e_ip = 0;
    if (!reset) begin
      m_q.delete(); m_str.delete(); m_pat.delete();
      m_phase = 0; m_wcnt = 0;
      m_ovf = 0; m_rm = 0; m_rt = 0; m_ri = 0;
    end else begin
      case (m_phase)
        0: begin
          if (start && m_pat.size() != 0) begin
            m_q.delete();
            foreach (m_str[i]) begin e.c = m_str[i]; e.s = 1; e.p = 0; m_q.push_back(e); end
            foreach (m_pat[i]) begin e.c = m_pat[i]; e.s = 0; e.p = 1; m_q.push_back(e); end
            m_rm = 0; m_rt = 0; m_ri = 0; m_ovf = 0;
            m_phase = 1;
            pop_emit();
          end else if (wr_en) begin
            if (!wr_sel) begin
              if (m_str.size() == 32) m_ovf = 1; else m_str.push_back(wr_data);
            end else begin
              if (m_pat.size() == 8) m_ovf = 1; else m_pat.push_back(wr_data);
            end
          end
        end
        1: begin
          if (m_q.size() == 0) begin m_phase = 2; m_wcnt = 0; end
          else pop_emit();
        end
        2: begin
          if (valid) begin
            m_rm = match; m_ri = match_index; m_rt = 0; e_done = 1; m_phase = 3;
          end else if (m_wcnt == TO) begin
            m_rm = 0; m_ri = 0; m_rt = 1; e_done = 1; m_phase = 3;
          end else m_wcnt++;
        end
        default: begin
          m_phase = 0; m_str.delete(); m_pat.delete();
        end
      endcase
    end
    e_busy = (m_phase != 0);
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      checks++;
      if ({chardata, isstring, ispattern, busy, done, res_match, res_index, res_timeout, overflow} !==
          {e_cd, e_is, e_ip, e_busy, e_done, m_rm, m_ri, m_rt, m_ovf}) begin
        errors++;
        $display("FAIL model-compare cycle %0d: got cd=%h is=%b ip=%b busy=%b done=%b m=%b idx=%0d to=%b ovf=%b; expected cd=%h is=%b ip=%b busy=%b done=%b m=%b idx=%0d to=%b ovf=%b",
                 cyc, chardata, isstring, ispattern, busy, done, res_match, res_index, res_timeout, overflow,
                 e_cd, e_is, e_ip, e_busy, e_done, m_rm, m_ri, m_rt, m_ovf);
      end
      checks++;
      if (isstring && ispattern) begin
        errors++;
        $display("FAIL flag-exclusive cycle %0d: got isstring=1 ispattern=1, expected not both", cyc);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_char(input logic sel, input logic [7:0] d);
    wr_en = 1; wr_sel = sel; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic start_job();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    string s1, p1, p2;
    int n;
    s1 = "ab cde"; p1 = "cd"; p2 = "^x$";

    // Reset
    tick(); tick();
    @(negedge clk);
    check_lit("reset outputs", {chardata, isstring, ispattern, busy, done, res_match, res_index, res_timeout, overflow}, 0);
    tick();
    reset = 1;
    tick();

    // Basic job
    for (int k = 0; k < 6; k++) write_char(0, s1[k]);
    for (int k = 0; k < 2; k++) write_char(1, p1[k]);
    start_job();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_lit("t1 string char", {isstring, ispattern, chardata}, {1'b1, 1'b0, s1[k]});
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_lit("t1 pattern char", {isstring, ispattern, chardata}, {1'b0, 1'b1, p1[k]});
      tick();
    end
    @(negedge clk);
    check_lit("t1 wait idle", {isstring, ispattern, chardata, busy}, {10'd0, 1'b1});
    tick(); tick(); tick();
    valid = 1; match = 1; match_index = 6'd3;
    tick();
    valid = 0; match = 0; match_index = 0;
    @(negedge clk);
    check_lit("t1 result", {done, res_match, res_index, res_timeout}, {1'b1, 1'b1, 6'd3, 1'b0});
    tick();
    @(negedge clk);
    check_lit("t1 after done", {busy, done, res_match, res_index}, {1'b0, 1'b0, 1'b1, 6'd3});
    tick();

    // Pattern-only job
    for (int k = 0; k < 3; k++) write_char(1, p2[k]);
    start_job();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_lit("t2 pattern char", {isstring, ispattern, chardata}, {1'b0, 1'b1, p2[k]});
      tick();
    end
    @(negedge clk);
    valid = 1; match = 0; match_index = 6'd5;
    tick();
    valid = 0;
    @(negedge clk);
    check_lit("t2 result", {done, res_match}, {1'b1, 1'b0});
    tick(); tick();

    // Start with empty pattern
    start_job();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_lit("t3 empty start", {busy, done}, 0);
      tick();
    end

    // Overflow then timeout
    for (int k = 0; k < 33; k++) write_char(0, 8'($urandom_range(32, 126)));
    @(negedge clk);
    check_lit("t4 overflow set", overflow, 1);
    write_char(1, "z");
    start_job();
    n = 1;
    @(negedge clk);
    check_lit("t4 overflow cleared", {overflow, isstring}, {1'b0, 1'b1});
    while (!done && n < 200) begin
      tick(); n++;
      @(negedge clk);
    end
    check_lit("t4 timeout latency", n, 50);
    check_lit("t4 timeout result", {done, res_timeout, res_match, res_index}, {1'b1, 1'b1, 1'b0, 6'd0});
    tick(); tick();

    // Reset during SEND_STR
    for (int k = 0; k < 5; k++) write_char(0, "h" + 8'(k));
    write_char(1, "l");
    start_job();
    tick();
    reset = 0;
    tick();
    reset = 1;
    @(negedge clk);
    check_lit("t5 reset mid-job", {busy, isstring, ispattern, chardata, done}, 0);
    tick();
    start_job();
    @(negedge clk);
    check_lit("t5 start ignored", busy, 0);
    tick();

    // Stray valid/start/wr_en outside their windows
    for (int k = 0; k < 4; k++) write_char(0, "a" + 8'(k));
    for (int k = 0; k < 3; k++) write_char(1, "x" + 8'(k));
    start_job();
    tick(); tick(); tick(); tick();
    valid = 1; match = 1; match_index = 6'd7;
    tick();
    valid = 0; match = 0; match_index = 0;
    tick(); tick(); tick();
    start = 1; wr_en = 1; wr_sel = 1; wr_data = "q";
    tick();
    start = 0; wr_en = 0;
    tick();
    valid = 1; match = 0; match_index = 6'd2;
    tick();
    valid = 0;
    @(negedge clk);
    check_lit("t6 wait result", {done, res_match, res_index}, {1'b1, 1'b0, 6'd2});
    tick(); tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(0, 299) != 0);
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_sel      = ($urandom_range(0, 3) == 0);
      wr_data     = 8'($urandom);
      start       = ($urandom_range(0, 15) == 0);
      valid       = ($urandom_range(0, 7) == 0);
      match       = 1'($urandom);
      match_index = 6'($urandom);
      tick();
    end
    reset = 1; wr_en = 0; start = 0; valid = 0;
    for (int c = 0; c < 60; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
